// File: rtl/tdes_ctrl.sv
// rtl/tdes_ctrl.sv - Triple-DES EDE sequencer driving one shared single-DES core.
// Runs three guarded passes per block and returns the result with a one-cycle strobe.
module tdes_ctrl #(
  parameter int WATCHDOG = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mode_i,
  input  logic [0:63] key1_i,
  input  logic [0:63] key2_i,
  input  logic [0:63] key3_i,
  input  logic [0:63] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [0:63] data_o,
  output logic        valid_o,
  output logic        err_o,
  output logic        des_mode_o,
  output logic [0:63] des_key_o,
  output logic [0:63] des_data_o,
  output logic        des_valid_o,
  input  logic [0:63] des_data_i,
  input  logic        des_valid_i
);

  localparam logic [7:0] WD_LIMIT = 8'(WATCHDOG);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, PASS3} state_t;

  state_t      state, state_nxt;
  logic        mode_r;
  logic [0:63] key1_r, key2_r, key3_r;
  logic        issue_r;
  logic [7:0]  wd_cnt;
  logic        accept, done, timeout;

  assign ready_o     = (state == IDLE);
  assign des_valid_o = issue_r;
  assign accept      = valid_i && ready_o;
  // The core's strobe only counts after the issue cycle; completion beats timeout.
  assign done        = (state != IDLE) && !issue_r && des_valid_i;
  assign timeout     = (state != IDLE) && !issue_r && !des_valid_i && (wd_cnt == WD_LIMIT);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PASS1;
      PASS1:   if (done) state_nxt = PASS2; else if (timeout) state_nxt = IDLE;
      PASS2:   if (done) state_nxt = PASS3; else if (timeout) state_nxt = IDLE;
      PASS3:   if (done || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      mode_r     <= 1'b0;
      key1_r     <= '0;
      key2_r     <= '0;
      key3_r     <= '0;
      issue_r    <= 1'b0;
      wd_cnt     <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      err_o      <= 1'b0;
      des_mode_o <= 1'b0;
      des_key_o  <= '0;
      des_data_o <= '0;
    end else begin
      issue_r <= 1'b0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      if (state != IDLE) wd_cnt <= wd_cnt + 8'd1;

      if (accept) begin
        mode_r     <= mode_i;
        key1_r     <= key1_i;
        key2_r     <= key2_i;
        key3_r     <= key3_i;
        des_mode_o <= mode_i;
        des_key_o  <= mode_i ? key3_i : key1_i;
        des_data_o <= data_i;
        issue_r    <= 1'b1;
        wd_cnt     <= '0;
      end

      // EDE order: encrypt E(K1) D(K2) E(K3); decrypt D(K3) E(K2) D(K1).
      if (done && state == PASS1) begin
        des_mode_o <= ~mode_r;
        des_key_o  <= key2_r;
        des_data_o <= des_data_i;
        issue_r    <= 1'b1;
        wd_cnt     <= '0;
      end

      if (done && state == PASS2) begin
        des_mode_o <= mode_r;
        des_key_o  <= mode_r ? key1_r : key3_r;
        des_data_o <= des_data_i;
        issue_r    <= 1'b1;
        wd_cnt     <= '0;
      end

      if (done && state == PASS3) begin
        data_o  <= des_data_i;
        valid_o <= 1'b1;
      end

      if (timeout) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tdes_ctrl.sv
// tb/tb_tdes_ctrl.sv - Randomized self-checking bench for tdes_ctrl with a DES core stub.
// Expected results come from a DES/TDES reference model composed at block level.
module tb_tdes_ctrl;

  localparam int WD = 16;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [0:63] key1_i = '0, key2_i = '0, key3_i = '0, data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o, valid_o, err_o, des_mode_o, des_valid_o;
  logic [0:63] data_o, des_key_o, des_data_o;
  logic [0:63] des_data_i = '0;
  logic        des_valid_i = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  tdes_ctrl #(.WATCHDOG(WD)) dut (
    .clk_i(clk), .reset_i(reset_i), .mode_i(mode_i),
    .key1_i(key1_i), .key2_i(key2_i), .key3_i(key3_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .err_o(err_o),
    .des_mode_o(des_mode_o), .des_key_o(des_key_o), .des_data_o(des_data_o),
    .des_valid_o(des_valid_o), .des_data_i(des_data_i), .des_valid_i(des_valid_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int ip_t[64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                   64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                   61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int fp_t[64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                   37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                   34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  int e_t[48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                   16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int p_t[32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                   2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int pc1_t[56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                    19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_t[48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int sh_t[16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int sb[512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // DES bit n (1-based, MSB first) lives at index n-1 of a [0:63] vector.
  function automatic logic [0:63] des_fn(input logic [0:63] key, input logic [0:63] din,
                                         input logic dec);
    logic [0:55] cd;
    logic [0:27] c, d;
    logic [0:47] sk[16];
    logic [0:63] x, pre, y;
    logic [0:31] l, r, f, pf, t;
    logic [0:47] ex;
    logic [0:5]  six;
    for (int i = 0; i < 56; i++) cd[i] = key[pc1_t[i]-1];
    c = cd[0:27];
    d = cd[28:55];
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < sh_t[n]; s++) begin
        c = {c[1:27], c[0]};
        d = {d[1:27], d[0]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) sk[n][i] = cd[pc2_t[i]-1];
    end
    for (int i = 0; i < 64; i++) x[i] = din[ip_t[i]-1];
    l = x[0:31];
    r = x[32:63];
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 48; i++) ex[i] = r[e_t[i]-1];
      ex = ex ^ (dec ? sk[15-n] : sk[n]);
      for (int s = 0; s < 8; s++) begin
        six = ex[6*s +: 6];
        f[4*s +: 4] = 4'(sb[s*64 + int'({six[0], six[5]})*16 + int'(six[1:4])]);
      end
      for (int i = 0; i < 32; i++) pf[i] = f[p_t[i]-1];
      t = r;
      r = l ^ pf;
      l = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) y[i] = pre[fp_t[i]-1];
    return y;
  endfunction

  function automatic logic [0:63] tdes_model(input logic m, input logic [0:63] k1, k2, k3, din);
    if (!m) return des_fn(k3, des_fn(k2, des_fn(k1, din, 1'b0), 1'b1), 1'b0);
    return des_fn(k1, des_fn(k2, des_fn(k3, din, 1'b1), 1'b0), 1'b1);
  endfunction

  // Core stub plus event monitor, both sampled on the falling edge.
  int          lat = 1;
  int          drop_n = 0;
  int          issue_n = 0;
  int          pend = 0;
  logic        stray = 1'b0;
  logic        chk = 1'b0;
  logic [0:63] resp = '0, h_key = '0, h_data = '0;
  logic        h_mode = 1'b0;
  int          iss_cyc[$];
  logic        iss_mode[$];
  logic [0:63] iss_key[$];
  int          vo_cyc[$];
  logic [0:63] vo_data[$];
  int          er_cyc[$];
  logic        er_rdy[$];
  int          rdy_q[$];
  logic [0:63] last_good = '0;

  always @(negedge clk) begin
    des_valid_i = stray;
    if (!reset_i) chk = 1'b0;
    if (chk) begin
      checks++;
      if (des_key_o !== h_key || des_data_o !== h_data || des_mode_o !== h_mode) begin
        failures++;
        $display("FAIL core_inputs_stable cyc=%0d got key=%h data=%h mode=%b exp key=%h data=%h mode=%b",
                 cyc, des_key_o, des_data_o, des_mode_o, h_key, h_data, h_mode);
      end
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        des_valid_i = 1'b1;
        des_data_i  = resp;
        chk         = 1'b0;
      end
    end
    if (des_valid_o) begin
      issue_n++;
      iss_cyc.push_back(cyc);
      iss_mode.push_back(des_mode_o);
      iss_key.push_back(des_key_o);
      resp = des_fn(des_key_o, des_data_o, des_mode_o);
      if (issue_n == drop_n) begin
        pend = WD + 5;
        chk  = 1'b0;
      end else begin
        pend   = lat;
        chk    = 1'b1;
        h_key  = des_key_o;
        h_data = des_data_o;
        h_mode = des_mode_o;
      end
    end
    if (valid_o) begin
      vo_cyc.push_back(cyc);
      vo_data.push_back(data_o);
    end
    if (err_o) begin
      er_cyc.push_back(cyc);
      er_rdy.push_back(ready_o);
    end
    if (ready_o) rdy_q.push_back(cyc);
  end

  task automatic start_block(input logic m, input logic [0:63] k1, k2, k3, d, input int l,
                             output int acc);
    int n;
    lat = l;
    issue_n = 0;
    iss_cyc.delete(); iss_mode.delete(); iss_key.delete();
    vo_cyc.delete(); vo_data.delete(); er_cyc.delete(); er_rdy.delete();
    @(negedge clk);
    n = 0;
    while (!ready_o && n < 200) begin @(negedge clk); n++; end
    mode_i = m; key1_i = k1; key2_i = k2; key3_i = k3; data_i = d;
    valid_i = 1'b1;
    acc = cyc;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic run_block(input string name, input logic m, input logic [0:63] k1, k2, k3, d,
                           input int l, output logic [0:63] got);
    int acc, n;
    logic [0:63] exp;
    logic [0:63] ek[3];
    start_block(m, k1, k2, k3, d, l, acc);
    n = 0;
    while (vo_cyc.size() == 0 && n < 3*l + 30) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    exp = tdes_model(m, k1, k2, k3, d);
    ek[0] = m ? k3 : k1; ek[1] = k2; ek[2] = m ? k1 : k3;
    got = (vo_data.size() > 0) ? vo_data[0] : '0;
    checks++;
    if (vo_cyc.size() != 1 || er_cyc.size() != 0) begin
      failures++;
      $display("FAIL %s_strobe_count got valid=%0d err=%0d exp valid=1 err=0", name, vo_cyc.size(), er_cyc.size());
    end
    checks++;
    if (iss_cyc.size() != 3) begin
      failures++;
      $display("FAIL %s_issue_count got=%0d exp=3", name, iss_cyc.size());
    end
    if (vo_cyc.size() == 1 && iss_cyc.size() == 3) begin
      checks++;
      if (vo_cyc[0] != acc + 3*l + 4) begin
        failures++;
        $display("FAIL %s_valid_cycle got=%0d exp=%0d", name, vo_cyc[0] - acc, 3*l + 4);
      end
      checks++;
      if (vo_data[0] !== exp) begin
        failures++;
        $display("FAIL %s_result got=%h exp=%h", name, vo_data[0], exp);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (iss_cyc[i] != acc + 1 + i*(l+1) || iss_mode[i] !== (m ^ (i == 1)) || iss_key[i] !== ek[i]) begin
          failures++;
          $display("FAIL %s_issue%0d got cyc=%0d mode=%b key=%h exp cyc=%0d mode=%b key=%h", name, i+1,
                   iss_cyc[i] - acc, iss_mode[i], iss_key[i], 1 + i*(l+1), m ^ (i == 1), ek[i]);
        end
      end
      last_good = exp;
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || err_o !== 1'b0 || des_valid_o !== 1'b0 || des_mode_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got rdy=%b vo=%b err=%b dv=%b dm=%b exp 1 0 0 0 0",
               ready_o, valid_o, err_o, des_valid_o, des_mode_o);
    end
    checks++;
    if (data_o !== 64'h0 || des_key_o !== 64'h0 || des_data_o !== 64'h0) begin
      failures++;
      $display("FAIL reset_data got data=%h key=%h ddata=%h exp 0", data_o, des_key_o, des_data_o);
    end
  endtask

  task automatic test_kat;
    logic [0:63] got;
    logic [0:63] k = 64'h133457799BBCDFF1;
    run_block("kat_enc", 1'b0, k, k, k, 64'h0123456789ABCDEF, 1, got);
    checks++;
    if (got !== 64'h85E813540F0AB405) begin
      failures++;
      $display("FAIL kat_enc_vector got=%h exp=85e813540f0ab405", got);
    end
    run_block("kat_dec", 1'b1, k, k, k, 64'h85E813540F0AB405, 2, got);
    checks++;
    if (got !== 64'h0123456789ABCDEF) begin
      failures++;
      $display("FAIL kat_dec_vector got=%h exp=0123456789abcdef", got);
    end
    run_block("kat3_enc", 1'b0, 64'h0123456789ABCDEF, 64'h23456789ABCDEF01, 64'h456789ABCDEF0123,
              64'h5468652071756663, 3, got);
    checks++;
    if (got !== 64'hA826FD8CE53B855F) begin
      failures++;
      $display("FAIL kat3_enc_vector got=%h exp=a826fd8ce53b855f", got);
    end
    run_block("kat3_dec", 1'b1, 64'h0123456789ABCDEF, 64'h23456789ABCDEF01, 64'h456789ABCDEF0123,
              64'hA826FD8CE53B855F, 1, got);
    checks++;
    if (got !== 64'h5468652071756663) begin
      failures++;
      $display("FAIL kat3_dec_vector got=%h exp=5468652071756663", got);
    end
  endtask

  task automatic test_random;
    logic [0:63] got;
    for (int i = 0; i < 4; i++)
      run_block("rand", 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(1, 5)), got);
  endtask

  task automatic test_back_to_back;
    localparam int L = 2;
    int acc[10];
    logic [0:63] exp[10];
    logic [0:63] k1, k2, k3;
    int n, rc;
    k1 = {$urandom, $urandom}; k2 = {$urandom, $urandom}; k3 = {$urandom, $urandom};
    lat = L;
    issue_n = 0;
    vo_cyc.delete(); vo_data.delete(); er_cyc.delete(); er_rdy.delete();
    @(negedge clk);
    key1_i = k1; key2_i = k2; key3_i = k3;
    valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (!ready_o && n < 100) begin @(negedge clk); n++; end
      mode_i = 1'($urandom_range(0, 1));
      data_i = {$urandom, $urandom};
      exp[i] = tdes_model(mode_i, k1, k2, k3, data_i);
      acc[i] = cyc;
      @(negedge clk);
    end
    valid_i = 1'b0;
    n = 0;
    while (vo_cyc.size() < 10 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (vo_cyc.size() != 10 || er_cyc.size() != 0) begin
      failures++;
      $display("FAIL b2b_count got valid=%0d err=%0d exp valid=10 err=0", vo_cyc.size(), er_cyc.size());
    end
    if (vo_cyc.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (vo_cyc[i] != acc[0] + (i+1)*(3*L+4) || vo_data[i] !== exp[i]) begin
          failures++;
          $display("FAIL b2b_block%0d got cyc=%0d data=%h exp cyc=%0d data=%h", i,
                   vo_cyc[i] - acc[0], vo_data[i], (i+1)*(3*L+4), exp[i]);
        end
      end
      rc = 0;
      foreach (rdy_q[j]) if (rdy_q[j] >= acc[0] && rdy_q[j] <= vo_cyc[9]) rc++;
      checks++;
      if (rc != 11) begin
        failures++;
        $display("FAIL b2b_ready_cycles got=%0d exp=11", rc);
      end
      last_good = exp[9];
    end
  endtask

  task automatic test_watchdog;
    int acc, n;
    drop_n = 2;
    start_block(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, 2, acc);
    n = 0;
    while (er_cyc.size() == 0 && n < WD + 40) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    checks++;
    if (er_cyc.size() != 1 || vo_cyc.size() != 0) begin
      failures++;
      $display("FAIL wd_strobes got err=%0d valid=%0d exp err=1 valid=0", er_cyc.size(), vo_cyc.size());
    end
    checks++;
    if (iss_cyc.size() != 2) begin
      failures++;
      $display("FAIL wd_issue_count got=%0d exp=2", iss_cyc.size());
    end
    if (er_cyc.size() == 1 && iss_cyc.size() >= 2) begin
      checks++;
      if (er_cyc[0] != iss_cyc[1] + WD + 1 || er_rdy[0] !== 1'b1) begin
        failures++;
        $display("FAIL wd_err_timing got delay=%0d ready=%b exp delay=%0d ready=1",
                 er_cyc[0] - iss_cyc[1], er_rdy[0], WD + 1);
      end
    end
    checks++;
    if (data_o !== last_good || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL wd_hold got data=%h rdy=%b exp data=%h rdy=1", data_o, ready_o, last_good);
    end
    drop_n = 0;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (iss_cyc.size() != 2 || vo_cyc.size() != 0 || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL stray_idle got issues=%0d valid=%0d rdy=%b exp issues=2 valid=0 rdy=1",
               iss_cyc.size(), vo_cyc.size(), ready_o);
    end
  endtask

  task automatic test_reset_mid;
    int acc, n;
    logic [0:63] got;
    start_block(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, 3, acc);
    n = 0;
    while (iss_cyc.size() < 3 && n < 60) begin @(negedge clk); n++; end
    @(negedge clk);
    #2 reset_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || err_o !== 1'b0 || des_valid_o !== 1'b0 || des_mode_o !== 1'b0 ||
        data_o !== 64'h0 || des_key_o !== 64'h0 || des_data_o !== 64'h0) begin
      failures++;
      $display("FAIL midreset_outputs got rdy=%b vo=%b err=%b dv=%b dm=%b data=%h key=%h dd=%h exp reset values",
               ready_o, valid_o, err_o, des_valid_o, des_mode_o, data_o, des_key_o, des_data_o);
    end
    @(negedge clk);
    #2 reset_i = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (vo_cyc.size() != 0 || er_cyc.size() != 0 || iss_cyc.size() != 3) begin
      failures++;
      $display("FAIL midreset_quiet got valid=%0d err=%0d issues=%0d exp 0 0 3",
               vo_cyc.size(), er_cyc.size(), iss_cyc.size());
    end
    run_block("post_reset", 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, 1, got);
  endtask

  initial begin
    test_reset();
    test_kat();
    test_random();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdes_ctrl.md
# tdes_ctrl

Triple-DES (EDE) sequencer that drives a single shared `des` core three times per block. It accepts a 64-bit data block plus three keys from the host side. It issues three single-DES passes to the core with the correct key/mode order, and returns the final result with a one-cycle valid pulse. The block sits between the host data path and one `des` instance. It is latency-agnostic toward the core and guards every pass with a watchdog.

## Interface
- `WATCHDOG`, 64: maximum cycles to wait for `des_valid_i` after an issue before aborting; range 2..255.
- `clk_i`  in  1  clock, rising edge.
- `reset_i`  in  1  reset, asynchronous and active-low.
- `mode_i`  in  1  0 = encrypt, 1 = decrypt; sampled at accept.
- `key1_i`, `key2_i`, `key3_i`  in  64 each  TDES keys, `[0:63]` bit order; sampled at accept.
- `data_i`  in  64  input block, `[0:63]`.
- `valid_i`  in  1  input request.
- `ready_o`  out  1  high when a new block can be accepted.
- `data_o`  out  64  result block.
- `valid_o`  out  1  one-cycle result strobe.
- `err_o`  out  1  one-cycle watchdog-abort strobe.
- `des_mode_o`  out  1  to core `mode_i`.
- `des_key_o`  out  64  to core `key_i`.
- `des_data_o`  out  64  to core `data_i`.
- `des_valid_o`  out  1  to core `valid_i`; one-cycle issue strobe.
- `des_data_i`  in  64  from core `data_o`.
- `des_valid_i`  in  1  from core `valid_o`.

## Operation
- States: IDLE, PASS1, PASS2, PASS3.
- `ready_o` = (state == IDLE).
- Accept: `valid_i && ready_o`.
  - On accept, latch mode, all three keys and `data_i`, then go to PASS1.
- Pass order:
  - Encrypt: PASS1 E(K1), PASS2 D(K2), PASS3 E(K3).
  - Decrypt: PASS1 D(K3), PASS2 E(K2), PASS3 D(K1).
- Pass handling:
  - Entering any PASSn drives `des_mode_o`, `des_key_o` and `des_data_o` from registers, and pulses `des_valid_o` for exactly that first cycle.
  - The core inputs stay stable until the pass completes.
  - PASS1 data is the latched input. PASS2 and PASS3 data is `des_data_i` captured at the previous pass's completion.
- Pass completion is `des_valid_i` high in any cycle after the issue cycle.
  - PASS1 goes to PASS2; PASS2 goes to PASS3.
  - PASS3 registers `des_data_i` into `data_o`, pulses `valid_o` next cycle, and goes to IDLE.
- `des_valid_i` is ignored in IDLE and in issue cycles. Stray strobes never advance state.
- `valid_i` while `ready_o` is low is ignored; the host must hold it.
- Watchdog:
  - The counter clears at every issue and increments each waiting cycle.
  - If it reaches `WATCHDOG` without completion, pulse `err_o` for one cycle and go to IDLE.
  - An aborted block produces no `valid_o`, and `data_o` is unchanged.
  - Completion and timeout in the same cycle count as completion.
- `data_o` holds the last result until the next successful block.

## Timing
- Reset values:
  - IDLE, `ready_o` = 1.
  - `valid_o`, `err_o`, `des_valid_o`, `des_mode_o` = 0.
  - `data_o`, `des_key_o`, `des_data_o` = 0.
  - Watchdog counter = 0.
- Reset asserted mid-operation aborts immediately with no `valid_o` or `err_o`. The core's own in-flight result is ignored afterwards because the block is in IDLE.
- With core latency L ≥ 1 (`des_valid_i` L cycles after `des_valid_o`):
  - Accept at cycle 0.
  - Issues at cycles 1, L+2 and 2L+3.
  - `valid_o` at 3L+4.
- Back-to-back: `ready_o` is high in the `valid_o` cycle. A block accepted then issues PASS1 on the next cycle, giving one block per 3L+4 cycles.
- `err_o` occurs `WATCHDOG`+1 cycles after the stalled issue. `ready_o` is high in the `err_o` cycle.

## Test plan
- K1=K2=K3=133457799BBCDFF1, encrypt 0123456789ABCDEF -> `data_o` = 85E813540F0AB405 at cycle 3L+4.
  - Exactly three `des_valid_o` pulses with modes 0,1,0.
  - Issue keys in order K1,K2,K3.
- Same keys, decrypt 85E813540F0AB405 -> 0123456789ABCDEF.
  - Modes 1,0,1.
  - Issue keys in order K3,K2,K1.
- Distinct keys K1=0123456789ABCDEF, K2=23456789ABCDEF01, K3=456789ABCDEF0123, encrypt 5468652071756663 -> A826FD8CE53B855F; decrypt of that returns the plaintext.
- Ten back-to-back blocks with `valid_i` held high -> ten `valid_o` pulses spaced 3L+4 apart, correct results in order, `ready_o` low except in IDLE cycles.
- Core stub that never answers PASS2 -> `err_o` pulse WATCHDOG+1 cycles after the PASS2 issue, no `valid_o`, `data_o` unchanged, `ready_o` = 1. A late `des_valid_i` afterwards is ignored.
- Reset pulse during PASS3 -> all outputs return to reset values, no `valid_o`. The next block after reset completes correctly.
